fractal_sync_np_barrier_cam: RTL

N-port, N-arrival barrier table for the fractal synchronisation tree. It generalises the two-port, pair-toggling remote register file in two ways: any number of ports, and a configurable number of arrivals per barrier. Each line also carries an age counter so that a stale partial barrier is evicted and reported. The block sits at each tree node in place of the 1D remote RF; the 2D node instantiates two of them (horizontal and vertical).

---
 rtl/fractal_sync_pkg.sv | 28 ++
 rtl/fractal_sync_barrier_cam_line.sv | 88 ++++++++
 rtl/fractal_sync_np_barrier_cam.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fractal_sync_pkg.sv
// Shared types and width helpers for the fractal synchronisation tree.
// The barrier CAM derives all of its per-line field widths from these functions.
package fractal_sync_pkg;

  typedef enum logic [1:0] {
    RF_1D_PAIR,
    RF_2D_PAIR,
    BARRIER_CAM_RF
  } remote_rf_e;

  function automatic int cam_sig_w(input int level_w, input int id_w);
    return level_w + id_w;
  endfunction

  function automatic int cam_cnt_w(input int n_arrivals);
    return $clog2(n_arrivals + 1);
  endfunction

  // A 1-bit age field is kept even when eviction is disabled so ports stay legal.
  function automatic int cam_age_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

  function automatic int cam_occ_w(input int n_lines);
    return $clog2(n_lines + 1);
  endfunction

endpackage

// File: rtl/fractal_sync_barrier_cam_line.sv
// One barrier CAM line: valid/sig/cnt/age registers, per-port hit compare,
// arrival count add, saturating idle-age counter and expire flag.
module fractal_sync_barrier_cam_line
  import fractal_sync_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int SIG_W      = 6,
  parameter int CNT_W      = 2,
  parameter int AGE_W      = 1,
  parameter int N_ARRIVALS = 2,
  parameter int TIMEOUT    = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [SIG_W-1:0]   sig_i [N_PORTS],
  input  logic [N_PORTS-1:0] arr_i,
  input  logic               alloc_i,
  input  logic [SIG_W-1:0]   alloc_sig_i,
  input  logic [CNT_W-1:0]   alloc_cnt_i,
  input  logic               evict_i,
  output logic               valid_o,
  output logic [SIG_W-1:0]   sig_o,
  output logic [N_PORTS-1:0] hit_o,
  output logic               complete_o,
  output logic               expire_o
);

  localparam int SUM_W = $clog2(N_PORTS + N_ARRIVALS + 1);

  logic               r_valid;
  logic [SIG_W-1:0]   r_sig;
  logic [CNT_W-1:0]   r_cnt;
  logic [AGE_W-1:0]   r_age;

  logic [N_PORTS-1:0] w_hit;
  logic [SUM_W-1:0]   w_k;
  logic [SUM_W-1:0]   w_sum;
  logic               w_any_hit;
  logic               w_complete;
  logic [AGE_W-1:0]   w_age_inc;

  always_comb begin
    w_hit = '0;
    w_k   = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      w_hit[p] = r_valid && arr_i[p] && (sig_i[p] == r_sig);
      w_k      = w_k + SUM_W'(w_hit[p]);
    end
  end

  assign w_any_hit  = |w_hit;
  assign w_sum      = SUM_W'(r_cnt) + w_k;
  assign w_complete = w_any_hit && (w_sum >= SUM_W'(N_ARRIVALS));

  // Age saturates so a line that loses eviction arbitration stays expired.
  assign w_age_inc = (r_age == AGE_W'(TIMEOUT)) ? r_age : r_age + AGE_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_sig   <= '0;
      r_cnt   <= '0;
      r_age   <= '0;
    end else if (alloc_i) begin
      r_valid <= 1'b1;
      r_sig   <= alloc_sig_i;
      r_cnt   <= alloc_cnt_i;
      r_age   <= '0;
    end else if (w_complete || evict_i) begin
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_age   <= '0;
    end else if (w_any_hit) begin
      r_cnt   <= w_sum[CNT_W-1:0];
      r_age   <= '0;
    end else if (r_valid) begin
      r_age   <= w_age_inc;
    end
  end

  assign valid_o    = r_valid;
  assign sig_o      = r_sig;
  assign hit_o      = w_hit;
  assign complete_o = w_complete;
  assign expire_o   = (TIMEOUT > 0) && r_valid && !w_any_hit &&
                      (w_age_inc == AGE_W'(TIMEOUT));

endmodule

// File: rtl/fractal_sync_np_barrier_cam.sv
// N-port, N-arrival barrier table: groups same-signature arrivals, updates
// matching lines, allocates free lines by lowest port and evicts stale lines.
module fractal_sync_np_barrier_cam
  import fractal_sync_pkg::*;
#(
  parameter int N_PORTS     = 4,
  parameter int LEVEL_WIDTH = 2,
  parameter int ID_WIDTH    = 4,
  parameter int MAX_LEVEL   = 3,
  parameter int N_ARRIVALS  = 2,
  parameter int N_LINES     = 4,
  parameter int TIMEOUT     = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [LEVEL_WIDTH-1:0]          level_i [N_PORTS],
  input  logic [ID_WIDTH-1:0]             id_i [N_PORTS],
  input  logic [N_PORTS-1:0]              check_i,
  output logic [N_PORTS-1:0]              done_o,
  output logic [N_PORTS-1:0]              sig_err_o,
  output logic [N_PORTS-1:0]              full_err_o,
  output logic                            timeout_o,
  output logic [LEVEL_WIDTH+ID_WIDTH-1:0] timeout_sig_o,
  output logic [$clog2(N_LINES+1)-1:0]    occupancy_o
);

  localparam int SIG_W = cam_sig_w(LEVEL_WIDTH, ID_WIDTH);
  localparam int CNT_W = cam_cnt_w(N_ARRIVALS);
  localparam int AGE_W = cam_age_w(TIMEOUT);
  localparam int OCC_W = cam_occ_w(N_LINES);
  localparam int K_W   = $clog2(N_PORTS + 1);

  logic [SIG_W-1:0]   w_sig [N_PORTS];
  logic [N_PORTS-1:0] w_lvl_ok;
  logic [N_PORTS-1:0] w_arr;
  logic [N_PORTS-1:0] w_leader;
  logic [N_PORTS-1:0] w_grp_mask [N_PORTS];
  logic [K_W-1:0]     w_grp_k [N_PORTS];

  logic [N_LINES-1:0] w_line_valid;
  logic [SIG_W-1:0]   w_line_sig [N_LINES];
  logic [N_PORTS-1:0] w_line_hit [N_LINES];
  logic [N_LINES-1:0] w_line_complete;
  logic [N_LINES-1:0] w_line_expire;

  logic [N_PORTS-1:0] w_port_hit;
  logic [N_PORTS-1:0] w_line_done;
  logic [N_PORTS-1:0] w_bypass;
  logic [N_PORTS-1:0] w_full;
  logic [N_LINES-1:0] w_alloc;
  logic [SIG_W-1:0]   w_alloc_sig [N_LINES];
  logic [CNT_W-1:0]   w_alloc_cnt [N_LINES];
  logic [N_LINES-1:0] w_evict;
  logic               w_evict_any;
  logic [SIG_W-1:0]   w_evict_sig;
  logic [OCC_W-1:0]   w_occ_next;

  logic [N_PORTS-1:0] r_done;
  logic [N_PORTS-1:0] r_sig_err;
  logic [N_PORTS-1:0] r_full_err;
  logic               r_timeout;
  logic [SIG_W-1:0]   r_timeout_sig;
  logic [OCC_W-1:0]   r_occ;

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      w_sig[p]    = {level_i[p], id_i[p]};
      w_lvl_ok[p] = (int'(level_i[p]) <= MAX_LEVEL);
      w_arr[p]    = check_i[p] && w_lvl_ok[p];
    end
  end

  // The leader of a signature group is its lowest presenting port.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      w_leader[p]   = w_arr[p];
      w_grp_mask[p] = '0;
      w_grp_k[p]    = '0;
      for (int q = 0; q < N_PORTS; q++) begin
        if (w_arr[q] && w_arr[p] && (w_sig[q] == w_sig[p])) begin
          w_grp_mask[p][q] = 1'b1;
          w_grp_k[p]       = w_grp_k[p] + K_W'(1);
          if (q < p) w_leader[p] = 1'b0;
        end
      end
    end
  end

  for (genvar l = 0; l < N_LINES; l++) begin : g_line
    fractal_sync_barrier_cam_line #(
      .N_PORTS    (N_PORTS),
      .SIG_W      (SIG_W),
      .CNT_W      (CNT_W),
      .AGE_W      (AGE_W),
      .N_ARRIVALS (N_ARRIVALS),
      .TIMEOUT    (TIMEOUT)
    ) u_line (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .sig_i       (w_sig),
      .arr_i       (w_arr),
      .alloc_i     (w_alloc[l]),
      .alloc_sig_i (w_alloc_sig[l]),
      .alloc_cnt_i (w_alloc_cnt[l]),
      .evict_i     (w_evict[l]),
      .valid_o     (w_line_valid[l]),
      .sig_o       (w_line_sig[l]),
      .hit_o       (w_line_hit[l]),
      .complete_o  (w_line_complete[l]),
      .expire_o    (w_line_expire[l])
    );
  end

  always_comb begin
    w_port_hit  = '0;
    w_line_done = '0;
    for (int l = 0; l < N_LINES; l++) begin
      w_port_hit = w_port_hit | w_line_hit[l];
      if (w_line_complete[l]) w_line_done = w_line_done | w_line_hit[l];
    end
  end

  // Only lines invalid at the start of the cycle are allocatable.
  always_comb begin : p_alloc
    logic v_found;
    v_found  = 1'b0;
    w_bypass = '0;
    w_full   = '0;
    w_alloc  = '0;
    for (int l = 0; l < N_LINES; l++) begin
      w_alloc_sig[l] = '0;
      w_alloc_cnt[l] = '0;
    end
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_leader[p] && !w_port_hit[p]) begin
        if (int'(w_grp_k[p]) >= N_ARRIVALS) begin
          w_bypass = w_bypass | w_grp_mask[p];
        end else begin
          v_found = 1'b0;
          for (int l = 0; l < N_LINES; l++) begin
            if (!v_found && !w_line_valid[l] && !w_alloc[l]) begin
              v_found        = 1'b1;
              w_alloc[l]     = 1'b1;
              w_alloc_sig[l] = w_sig[p];
              w_alloc_cnt[l] = CNT_W'(w_grp_k[p]);
            end
          end
          if (!v_found) w_full = w_full | w_grp_mask[p];
        end
      end
    end
  end

  always_comb begin
    w_evict     = '0;
    w_evict_any = 1'b0;
    w_evict_sig = '0;
    for (int l = 0; l < N_LINES; l++) begin
      if (w_line_expire[l] && !w_evict_any) begin
        w_evict[l]  = 1'b1;
        w_evict_any = 1'b1;
        w_evict_sig = w_line_sig[l];
      end
    end
  end

  always_comb begin
    w_occ_next = '0;
    for (int l = 0; l < N_LINES; l++) begin
      if (w_alloc[l] || (w_line_valid[l] && !w_line_complete[l] && !w_evict[l]))
        w_occ_next = w_occ_next + OCC_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done        <= '0;
      r_sig_err     <= '0;
      r_full_err    <= '0;
      r_timeout     <= 1'b0;
      r_timeout_sig <= '0;
      r_occ         <= '0;
    end else begin
      r_done        <= w_line_done | w_bypass;
      r_sig_err     <= check_i & ~w_lvl_ok;
      r_full_err    <= w_full;
      r_timeout     <= w_evict_any;
      r_timeout_sig <= w_evict_sig;
      r_occ         <= w_occ_next;
    end
  end

  assign done_o        = r_done;
  assign sig_err_o     = r_sig_err;
  assign full_err_o    = r_full_err;
  assign timeout_o     = r_timeout;
  assign timeout_sig_o = r_timeout_sig;
  assign occupancy_o   = r_occ;

endmodule
